aes_cipher_wb: RTL and testbench

Downstream writeback stage for the AES core in the cpu_aes subsystem. Arms when the CPU stores to the AES trigger address and stalls the CPU via wait_en. Captures the 128-bit cipher on the rising edge of Dvld, then writes it as four 32-bit words into the data cache's dedicated AES write port (wen_aes_d / cipher_addr / cipher_text). Replaces the ad-hoc top-level sequencer with a proper FSM, ready handshake and timeout.

---
 rtl/aes_wb_pkg.sv | 33 +++
 rtl/aes_cipher_wb.sv | 126 ++++++++++++
 tb/tb_aes_cipher_wb.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_wb_pkg.sv
// Shared types and helpers for the AES cipher writeback stage.
// Optional build macro: CWB_OVERRUN_CNT_EN (see aes_cipher_wb).
package aes_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    localparam int NBEATS = 4;
    localparam int WORD_W = 32;
    localparam logic [1:0] LAST_BEAT = 2'(NBEATS - 1);

    // Word 0 is the most significant word of the block.
    function automatic logic [WORD_W-1:0] cipher_word(
        input logic [127:0] blk,
        input logic [1:0]   idx
    );
        logic [WORD_W-1:0] w;
        w = '0;
        unique case (idx)
            2'd0: w = blk[127:96];
            2'd1: w = blk[95:64];
            2'd2: w = blk[63:32];
            2'd3: w = blk[31:0];
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_cipher_wb.sv
// AES cipher writeback: arm on CPU store, capture on Dvld rise, write 4 beats.
// Define CWB_OVERRUN_CNT_EN to add the overrun_cnt output for dropped edges.
module aes_cipher_wb
    import aes_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000004C,
    parameter logic [31:0] ARM_ADDR  = 32'h00000030,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  cpu_add,
    input  logic [3:0]   cpu_wen,
    input  logic [127:0] cipher,
    input  logic         Dvld,
    input  logic         wb_rdy,
    output logic         wait_en,
    output logic         wen_aes_d,
    output logic [31:0]  cipher_addr,
    output logic [31:0]  cipher_text,
    output logic         busy,
    output logic         done,
`ifdef CWB_OVERRUN_CNT_EN
    output logic [7:0]   overrun_cnt,
`endif
    output logic         timeout
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    wb_state_t    state;
    logic         dvld_q;
    logic [1:0]   beat;
    logic [127:0] blk;
    logic [31:0]  timer;

    logic       rise;
    logic       arm;
    logic [1:0] nxt_beat;

    assign rise     = Dvld & ~dvld_q;
    assign arm      = (cpu_add == ARM_ADDR) & (|cpu_wen);
    assign nxt_beat = beat + 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            dvld_q      <= 1'b0;
            beat        <= 2'd0;
            blk         <= '0;
            timer       <= '0;
            wait_en     <= 1'b0;
            wen_aes_d   <= 1'b0;
            cipher_addr <= '0;
            cipher_text <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            dvld_q  <= Dvld;
            done    <= 1'b0;
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arm) begin
                        state   <= ARMED;
                        wait_en <= 1'b1;
                        busy    <= 1'b1;
                        timer   <= '0;
                    end
                end
                ARMED: begin
                    timer <= timer + 32'd1;
                    // A capture edge wins over an expiring timer.
                    if (rise) begin
                        blk         <= cipher;
                        beat        <= 2'd0;
                        state       <= WRITE;
                        wen_aes_d   <= 1'b1;
                        cipher_addr <= BASE_ADDR;
                        cipher_text <= cipher[127:96];
                    end else if (TIMEOUT != 0 && timer == TO_LAST) begin
                        state   <= IDLE;
                        wait_en <= 1'b0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wb_rdy) begin
                        if (beat == LAST_BEAT) begin
                            state       <= DONE;
                            wen_aes_d   <= 1'b0;
                            cipher_addr <= '0;
                            cipher_text <= '0;
                            wait_en     <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            beat        <= nxt_beat;
                            cipher_addr <= BASE_ADDR + {28'd0, nxt_beat, 2'b00};
                            cipher_text <= cipher_word(blk, nxt_beat);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CWB_OVERRUN_CNT_EN
    // Counts capture edges dropped because a writeback is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_cnt <= '0;
        end else if (rise && (state == WRITE || state == DONE)
                     && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aes_cipher_wb.sv
// Directed self-checking bench for aes_cipher_wb (TIMEOUT set to 16).
module tb_aes_cipher_wb;

    logic         clk;
    logic         reset;
    logic [31:0]  cpu_add;
    logic [3:0]   cpu_wen;
    logic [127:0] cipher;
    logic         Dvld;
    logic         wb_rdy;
    logic         wait_en;
    logic         wen_aes_d;
    logic [31:0]  cipher_addr;
    logic [31:0]  cipher_text;
    logic         busy;
    logic         done;
    logic         timeout;
`ifdef CWB_OVERRUN_CNT_EN
    logic [7:0]   overrun_cnt;
`endif

    int checks;
    int failures;

    localparam logic [127:0] V1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] V2 = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;

    aes_cipher_wb #(
        .BASE_ADDR(32'h0000004C),
        .ARM_ADDR (32'h00000030),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_add    (cpu_add),
        .cpu_wen    (cpu_wen),
        .cipher     (cipher),
        .Dvld       (Dvld),
        .wb_rdy     (wb_rdy),
        .wait_en    (wait_en),
        .wen_aes_d  (wen_aes_d),
        .cipher_addr(cipher_addr),
        .cipher_text(cipher_text),
        .busy       (busy),
        .done       (done),
`ifdef CWB_OVERRUN_CNT_EN
        .overrun_cnt(overrun_cnt),
`endif
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic arm_store();
        cpu_add = 32'h30;
        cpu_wen = 4'hF;
        tick();
        cpu_add = 32'h0;
        cpu_wen = 4'h0;
    endtask

    task automatic dvld_rise();
        Dvld = 1'b1;
        tick();
        Dvld = 1'b0;
    endtask

    // Expects beat 0 already visible; drains all beats with wb_rdy=1.
    task automatic run_beats(input string tag, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_wen"}, 32'(wen_aes_d), 32'd1);
            chk({tag, "_addr"}, cipher_addr, 32'h4C + 32'(4 * i));
            chk({tag, "_data"}, cipher_text, blk[127 - 32 * i -: 32]);
            chk({tag, "_wait"}, 32'(wait_en), 32'd1);
            wb_rdy = 1'b1;
            tick();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_wen_off"}, 32'(wen_aes_d), 32'd0);
        chk({tag, "_wait_off"}, 32'(wait_en), 32'd0);
        chk({tag, "_addr_clr"}, cipher_addr, 32'd0);
        chk({tag, "_text_clr"}, cipher_text, 32'd0);
        tick();
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_addr [7];
        logic [31:0] exp_data [7];
        int wen_cnt;
        int k;
        bit wen_seen;

        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        cpu_add  = '0;
        cpu_wen  = '0;
        cipher   = '0;
        Dvld     = 1'b0;
        wb_rdy   = 1'b1;
        tick();
        tick();
        chk("rst_wait", 32'(wait_en), 32'd0);
        chk("rst_wen", 32'(wen_aes_d), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", cipher_addr, 32'd0);
        chk("rst_text", cipher_text, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        reset = 1'b1;
        tick();

        // Basic writeback, rise 5 cycles after arming.
        arm_store();
        chk("t1_armwait", 32'(wait_en), 32'd1);
        chk("t1_armbusy", 32'(busy), 32'd1);
        cipher = V1;
        for (int i = 0; i < 4; i++) begin
            chk("t1_nowen", 32'(wen_aes_d), 32'd0);
            tick();
        end
        dvld_rise();
        run_beats("t1", V1);

        // Three-cycle stall during beat 1.
        exp_addr = '{32'h4C, 32'h50, 32'h50, 32'h50, 32'h50, 32'h54, 32'h58};
        exp_data = '{32'h00112233, 32'h44556677, 32'h44556677, 32'h44556677,
                     32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        arm_store();
        tick();
        dvld_rise();
        wen_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            if (wen_aes_d) wen_cnt++;
            chk("t2_addr", cipher_addr, exp_addr[i]);
            chk("t2_data", cipher_text, exp_data[i]);
            wb_rdy = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
            tick();
        end
        chk("t2_wencnt", 32'(wen_cnt), 32'd7);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_wen_off", 32'(wen_aes_d), 32'd0);
        tick();

        // Timeout with no Dvld.
        arm_store();
        wen_seen = 1'b0;
        k = 41;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (wen_aes_d) wen_seen = 1'b1;
            if (timeout) begin
                k = i;
                break;
            end
        end
        chk("t3_cycles", 32'(k), 32'd16);
        chk("t3_wait", 32'(wait_en), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_nowen", 32'(wen_seen), 32'd0);
        tick();
        chk("t3_to_pulse", 32'(timeout), 32'd0);

        // Dvld toggled mid-writeback with a changed cipher.
        cipher = V1;
        arm_store();
        tick();
        wb_rdy = 1'b0;
        dvld_rise();
        cipher = '1;
        tick();
        Dvld = 1'b1;
        tick();
        Dvld = 1'b0;
        chk("t4_hold_addr", cipher_addr, 32'h4C);
        chk("t4_hold_data", cipher_text, 32'h00112233);
        run_beats("t4", V1);
`ifdef CWB_OVERRUN_CNT_EN
        chk("t4_overrun", 32'(overrun_cnt), 32'd1);
`endif

        // Reset during beat 2, then a clean writeback.
        cipher = V1;
        arm_store();
        tick();
        wb_rdy = 1'b1;
        dvld_rise();
        tick();
        tick();
        chk("t5_beat2", cipher_addr, 32'h54);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_wen", 32'(wen_aes_d), 32'd0);
        chk("t5_rst_wait", 32'(wait_en), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_addr", cipher_addr, 32'd0);
        chk("t5_rst_text", cipher_text, 32'd0);
`ifdef CWB_OVERRUN_CNT_EN
        chk("t5_rst_ovr", 32'(overrun_cnt), 32'd0);
`endif
        tick();
        reset = 1'b1;
        tick();
        cipher = V2;
        arm_store();
        tick();
        dvld_rise();
        run_beats("t5", V2);

        // Non-arming stores.
        cpu_add = 32'h34;
        cpu_wen = 4'hF;
        tick();
        chk("t6_addr34_wait", 32'(wait_en), 32'd0);
        chk("t6_addr34_busy", 32'(busy), 32'd0);
        cpu_add = 32'h30;
        cpu_wen = 4'h0;
        tick();
        tick();
        chk("t6_nowen_wait", 32'(wait_en), 32'd0);
        chk("t6_nowen_busy", 32'(busy), 32'd0);
        cpu_add = 32'h0;

        // Arm and rise in the same cycle: the rise is lost.
        cpu_add = 32'h30;
        cpu_wen = 4'hF;
        Dvld    = 1'b1;
        tick();
        cpu_add = 32'h0;
        cpu_wen = 4'h0;
        tick();
        chk("t7_armed", 32'(wait_en), 32'd1);
        chk("t7_nowen", 32'(wen_aes_d), 32'd0);
        Dvld = 1'b0;
        tick();
        cipher = V2;
        dvld_rise();
        run_beats("t7", V2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
